// File: rtl/mem_bus_arbiter_pkg.sv
// ============================================================================
// mem_bus_arbiter_pkg
// Shared definitions for the unified-memory arbiter: grant FSM state
// encoding, counter widths and a small state-decode helper.
// No ports (package).
// ============================================================================
package mem_bus_arbiter_pkg;

    // Width of the fetch anti-starvation counter (STARVE_MAX is at most 15).
    localparam int ARB_STARVE_W = 4;

    // Width of the transaction timeout counter (TIMEOUT is at most 255).
    localparam int ARB_TMO_W = 8;

    typedef enum logic [2:0] {
        ARB_IDLE   = 3'd0,
        ARB_BUSY_I = 3'd1,
        ARB_BUSY_D = 3'd2,
        ARB_DONE_I = 3'd3,
        ARB_DONE_D = 3'd4
    } arbState_e;

    function automatic logic isBusy(input arbState_e s);
        return (s == ARB_BUSY_I) || (s == ARB_BUSY_D);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_timeout.sv
// ============================================================================
// mem_bus_arbiter_timeout
// Counts BUSY cycles that pass without a memory acknowledge and flags the
// cycle in which the outstanding transaction has to be abandoned.
// Ports:
//   clk_i   clock, rising edge
//   rst_ni  asynchronous active-low reset
//   clr_i   restart the count (asserted on the grant cycle)
//   en_i    advance the count by one
//   hit_o   count has reached TIMEOUT-1
// ============================================================================
module mem_bus_arbiter_timeout
    import mem_bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    localparam logic [ARB_TMO_W-1:0] HIT_VAL = ARB_TMO_W'(TIMEOUT - 1);

    logic [ARB_TMO_W-1:0] cnt_q;
    logic [ARB_TMO_W-1:0] cnt_d;

    // Clear wins over enable so a new grant always starts from zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + ARB_TMO_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = (cnt_q == HIT_VAL);

endmodule

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// mem_bus_arbiter
// Shares one single-port unified memory between the CPU fetch port (i_*) and
// the data port (d_*). One transaction is outstanding at a time; data has
// priority unless fetch has been passed over STARVE_MAX times in a row.
// Transactions that never receive m_ack are aborted after TIMEOUT BUSY cycles.
// Ports:
//   clk, rst (async, active-low)
//   i_req/i_addr -> i_rdata/i_ready        fetch port
//   d_req/d_wr/d_addr/d_wdata -> d_rdata/d_ready   data port
//   m_req/m_wr/m_addr/m_wdata, m_rdata/m_ack       memory side
//   stall  combinational core stall
//   err    one-cycle pulse, together with ready, on a timeout abort
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              m_req,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_ack,
    output logic              stall,
    output logic              err
);

    localparam logic [ARB_STARVE_W-1:0] STARVE_LIM = ARB_STARVE_W'(STARVE_MAX);

    arbState_e state_q;
    arbState_e state_d;

    logic [ADDR_W-1:0]       mAddr_q;
    logic [ADDR_W-1:0]       mAddr_d;
    logic                    mWr_q;
    logic                    mWr_d;
    logic [DATA_W-1:0]       mWdata_q;
    logic [DATA_W-1:0]       mWdata_d;
    logic [DATA_W-1:0]       rdata_q;
    logic [DATA_W-1:0]       rdata_d;
    logic                    abort_q;
    logic                    abort_d;
    logic [ARB_STARVE_W-1:0] starveCnt_q;
    logic [ARB_STARVE_W-1:0] starveCnt_d;

    logic idle;
    logic busy;
    logic grantD;
    logic grantI;
    logic tmoHit;

    assign idle = (state_q == ARB_IDLE);
    assign busy = isBusy(state_q);

    // Data wins unless fetch is also waiting and has already been passed over
    // STARVE_MAX times; fetch takes every IDLE cycle that data does not.
    assign grantD = idle && d_req && ((starveCnt_q < STARVE_LIM) || !i_req);
    assign grantI = idle && i_req && !grantD;

    mem_bus_arbiter_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i  (clk),
        .rst_ni (rst),
        .clr_i  (grantD || grantI),
        .en_i   (busy && !m_ack),
        .hit_o  (tmoHit)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: an ack or a timeout both end the BUSY phase, so the
    // requester always sees a ready pulse.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (grantD) begin
                    state_d = ARB_BUSY_D;
                end else if (grantI) begin
                    state_d = ARB_BUSY_I;
                end
            end
            ARB_BUSY_I: begin
                if (m_ack || tmoHit) begin
                    state_d = ARB_DONE_I;
                end
            end
            ARB_BUSY_D: begin
                if (m_ack || tmoHit) begin
                    state_d = ARB_DONE_D;
                end
            end
            ARB_DONE_I, ARB_DONE_D: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // FSM outputs decoded from the state alone.
    always_comb begin
        m_req   = 1'b0;
        i_ready = 1'b0;
        d_ready = 1'b0;
        unique case (state_q)
            ARB_BUSY_I, ARB_BUSY_D: m_req   = 1'b1;
            ARB_DONE_I:             i_ready = 1'b1;
            ARB_DONE_D:             d_ready = 1'b1;
            default: begin
            end
        endcase
    end

    // Request latch, response capture and starvation bookkeeping. Reads of a
    // write and aborted transactions both return zero.
    always_comb begin
        mAddr_d     = mAddr_q;
        mWr_d       = mWr_q;
        mWdata_d    = mWdata_q;
        rdata_d     = rdata_q;
        abort_d     = abort_q;
        starveCnt_d = starveCnt_q;
        if (grantD) begin
            mAddr_d  = d_addr;
            mWr_d    = d_wr;
            mWdata_d = d_wdata;
            rdata_d  = '0;
            abort_d  = 1'b0;
            if (i_req && (starveCnt_q < STARVE_LIM)) begin
                starveCnt_d = starveCnt_q + ARB_STARVE_W'(1);
            end
        end else if (grantI) begin
            mAddr_d     = i_addr;
            mWr_d       = 1'b0;
            mWdata_d    = '0;
            rdata_d     = '0;
            abort_d     = 1'b0;
            starveCnt_d = '0;
        end else if (busy) begin
            if (m_ack) begin
                rdata_d = mWr_q ? '0 : m_rdata;
                abort_d = 1'b0;
            end else if (tmoHit) begin
                rdata_d = '0;
                abort_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mAddr_q     <= '0;
            mWr_q       <= 1'b0;
            mWdata_q    <= '0;
            rdata_q     <= '0;
            abort_q     <= 1'b0;
            starveCnt_q <= '0;
        end else begin
            mAddr_q     <= mAddr_d;
            mWr_q       <= mWr_d;
            mWdata_q    <= mWdata_d;
            rdata_q     <= rdata_d;
            abort_q     <= abort_d;
            starveCnt_q <= starveCnt_d;
        end
    end

    assign m_wr    = m_req && mWr_q;
    assign m_addr  = mAddr_q;
    assign m_wdata = mWdata_q;
    assign i_rdata = i_ready ? rdata_q : '0;
    assign d_rdata = d_ready ? rdata_q : '0;
    assign err     = (i_ready || d_ready) && abort_q;
    assign stall   = (i_req && !i_ready) || (d_req && !d_ready);

endmodule
